uart_host_port: RTL

Host-side UART endpoint with hardware flow control: the peer of the HSM's `rx`/`tx`/`cts`/`rts` pins, used by test harnesses and bridge boards to drive commands into the HSM and collect its responses. It serialises bytes from a valid/ready stream onto `tx`, gated by the peer's `cts`. It deserialises `rx` into a small FIFO and drives `rts` from FIFO occupancy. Frame format is fixed 8N1, LSB first, idle-high line.

---
 rtl/uart_host_port_if.sv | 28 ++
 rtl/uart_host_port.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_host_port_if.sv
// Host UART endpoint signal bundle: byte stream in, byte stream out,
// serial pins with hardware flow control, and sticky error flags.
// Ports: master = the uart_host_port itself; slave = the logic driving it.
interface uart_host_port_if;
  logic [7:0] in_data;      // byte to transmit
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;     // head of the receive FIFO
  logic       out_valid;
  logic       out_ready;
  logic       tx;           // serial out, idle high
  logic       rx;           // serial in, asynchronous
  logic       cts;          // peer may accept, asynchronous
  logic       rts;          // we may accept
  logic       overrun;      // sticky: byte dropped, FIFO full
  logic       framing_err;  // sticky: byte dropped, bad stop bit
  logic       err_clear;    // clears both sticky flags

  modport master (
    input  in_data, in_valid, out_ready, rx, cts, err_clear,
    output in_ready, out_data, out_valid, tx, rts, overrun, framing_err
  );

  modport slave (
    output in_data, in_valid, out_ready, rx, cts, err_clear,
    input  in_ready, out_data, out_valid, tx, rts, overrun, framing_err
  );
endinterface

// File: rtl/uart_host_port.sv
// Host-side 8N1 UART with cts/rts flow control and a fall-through receive FIFO.
// Latency: tx falls 1 cycle after the input handshake; a received byte is
//   pushed about 9.5 bit times after its start edge, visible on out_valid 1 cycle later.
// Backpressure: in_ready only in TX idle with cts asserted; rts drops at the
//   FIFO high-water mark; bytes arriving while the FIFO is full are dropped (overrun).
// Ports: clk, reset (sync, active high), bus (uart_host_port_if.master).
module uart_host_port #(
  parameter int CLKS_PER_BIT   = 16,
  parameter int FIFO_DEPTH     = 8,
  parameter int RTS_HIGH_WATER = 6
) (
  input  logic             clk,
  input  logic             reset,
  uart_host_port_if.master bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] BIT_LAST   = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [AW:0]   DEPTH_C    = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0]   HIGH_WATER = (AW + 1)'(RTS_HIGH_WATER);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // ---------------------------------------------------------------- sync
  logic rx_meta, rx_sync, cts_meta, cts_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      cts_meta <= 1'b0;
      cts_sync <= 1'b0;
    end else begin
      rx_meta  <= bus.rx;
      rx_sync  <= rx_meta;
      cts_meta <= bus.cts;
      cts_sync <= cts_meta;
    end
  end

  // ---------------------------------------------------------------- transmit
  state_t          tx_state;
  logic [CW-1:0]   tx_cnt;
  logic [2:0]      tx_bit;
  logic [7:0]      tx_shift;
  logic            tx_line;

  // cts only gates the start of a frame; a frame in flight always finishes.
  assign bus.in_ready = (tx_state == IDLE) && cts_sync;
  assign bus.tx       = tx_line;

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state <= IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_line  <= 1'b1;
    end else begin
      case (tx_state)
        IDLE: begin
          tx_line <= 1'b1;
          if (bus.in_valid && bus.in_ready) begin
            tx_shift <= bus.in_data;
            tx_cnt   <= '0;
            tx_line  <= 1'b0;
            tx_state <= START;
          end
        end
        START: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_line  <= tx_shift[0];
            tx_state <= DATA;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        DATA: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            // The line always shows bit 0 of the shifter; shift to expose the next.
            tx_shift <= tx_shift >> 1;
            if (tx_bit == 3'd7) begin
              tx_line  <= 1'b1;
              tx_state <= STOP;
            end else begin
              tx_bit  <= tx_bit + 1'b1;
              tx_line <= tx_shift[1];
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        STOP: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            tx_state <= IDLE;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: tx_state <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- receive
  state_t          rx_state;
  logic [CW-1:0]   rx_cnt;
  logic [2:0]      rx_bit;
  logic [7:0]      rx_shift;
  logic            rx_armed;   // line seen high since the last frame
  logic            rx_push;    // one-cycle pulse: rx_byte had a good stop bit
  logic [7:0]      rx_byte;
  logic            frame_evt;  // one-cycle pulse: stop bit was 0

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state  <= IDLE;
      rx_cnt    <= '0;
      rx_bit    <= '0;
      rx_shift  <= '0;
      rx_armed  <= 1'b0;
      rx_push   <= 1'b0;
      rx_byte   <= '0;
      frame_evt <= 1'b0;
    end else begin
      rx_push   <= 1'b0;
      frame_evt <= 1'b0;
      case (rx_state)
        IDLE: begin
          // After a frame (especially a framing error with the line still low)
          // the line must return high before a new start edge counts.
          if (rx_sync) begin
            rx_armed <= 1'b1;
          end else if (rx_armed) begin
            rx_cnt   <= '0;
            rx_state <= START;
          end
        end
        START: begin
          if (rx_cnt == HALF_LAST) begin
            // From here on rx_cnt wraps at mid-bit, so every later sample is centred.
            rx_cnt <= '0;
            if (rx_sync) begin
              rx_state <= IDLE;
            end else begin
              rx_bit   <= '0;
              rx_state <= DATA;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        DATA: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_sync, rx_shift[7:1]};
            if (rx_bit == 3'd7) begin
              rx_state <= STOP;
            end else begin
              rx_bit <= rx_bit + 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        STOP: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_armed <= 1'b0;
            rx_state <= IDLE;
            if (rx_sync) begin
              rx_push <= 1'b1;
              rx_byte <= rx_shift;
            end else begin
              frame_evt <= 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: rx_state <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- FIFO
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_next;
  logic          full, out_valid_i, do_push, do_pop;
  logic          rts_q, overrun_q, framing_q;

  // Full is judged on the registered count, so a same-cycle pop never makes room.
  assign full        = (count == DEPTH_C);
  assign out_valid_i = (count != '0);
  assign do_push     = rx_push && !full;
  assign do_pop      = out_valid_i && bus.out_ready;

  always_comb begin
    count_next = count;
    if (do_push && !do_pop)
      count_next = count + 1'b1;
    else if (!do_push && do_pop)
      count_next = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= rx_byte;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rts_q     <= 1'b0;
      overrun_q <= 1'b0;
      framing_q <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      rts_q <= (count_next < HIGH_WATER);
      // Set events take priority over a coincident clear.
      if (rx_push && full)    overrun_q <= 1'b1;
      else if (bus.err_clear) overrun_q <= 1'b0;
      if (frame_evt)          framing_q <= 1'b1;
      else if (bus.err_clear) framing_q <= 1'b0;
    end
  end

  // Masked when empty so stale storage never shows after reset or a drain.
  assign bus.out_data    = out_valid_i ? mem[rd_ptr] : 8'h00;
  assign bus.out_valid   = out_valid_i;
  assign bus.rts         = rts_q;
  assign bus.overrun     = overrun_q;
  assign bus.framing_err = framing_q;

endmodule
